// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : acc_pkg
// Description : Shared definitions for the accumulator output path: default
//               accumulator word width, output-mode enum and a helper that
//               sizes index registers.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

   localparam int DATA_WIDTH_DEFAULT = 16;

   typedef enum logic {
      MODE_BATCH  = 1'b0,
      MODE_STREAM = 1'b1
   } out_mode_e;

   // Width of an index into n words; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
// Module      : acc_bank
// Description : One ping-pong bank: ACC_WIDTH words of storage, a length
//               register and a full flag. Control logic lives in the parent.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               wr_en/wr_idx/wr_data - word write port
//               close/close_len      - mark bank full with given length
//               free                 - clear full flag
//               rd_idx/rd_data       - single-word read port
//               rd_vec               - all words, lane 0 in the LSBs
//               len/full             - stored length and full flag
// Revision    : 1.0 - initial release
// ============================================================================
module acc_bank
   import acc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int ACC_WIDTH  = 4,
   localparam int IDX_W     = idx_width(ACC_WIDTH),
   localparam int LEN_W     = $clog2(ACC_WIDTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [IDX_W-1:0]                 wr_idx,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             close,
   input  logic [LEN_W-1:0]                 close_len,
   input  logic                             free,
   input  logic [IDX_W-1:0]                 rd_idx,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic [ACC_WIDTH*DATA_WIDTH-1:0]  rd_vec,
   output logic [LEN_W-1:0]                 len,
   output logic                             full
);

   logic [DATA_WIDTH-1:0] mem [ACC_WIDTH];

   // Storage is not reset; stale contents are masked by len/full downstream.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // close and free never target the same bank in one cycle (close needs
   // the bank empty, free needs it full), so their order is immaterial.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         len  <= '0;
      end else if (close) begin
         full <= 1'b1;
         len  <= close_len;
      end else if (free) begin
         full <= 1'b0;
      end
   end

   assign rd_data = mem[rd_idx];

   for (genvar w = 0; w < ACC_WIDTH; w++) begin : g_word
      assign rd_vec[w*DATA_WIDTH +: DATA_WIDTH] = mem[w];
   end

endmodule
`default_nettype wire

// File: rtl/acc_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : acc_stream_buf
// Description : Ping-pong buffer between a systolic array's accumulator
//               outputs and a downstream consumer. Words are collected into
//               vectors of up to ACC_WIDTH words (in_last closes early) and
//               delivered either as a whole vector (batch) or one word per
//               beat (stream).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               mode_i          - 0 batch, 1 stream (latched when idle)
//               in_valid/in_ready/in_data/in_last - input word handshake
//               out_valid/out_ready               - output handshake
//               out_vec         - batch vector, lane 0 = first word
//               out_data        - stream word
//               out_last        - last word of vector (batch: = out_valid)
//               out_len         - words in the current vector
// Revision    : 1.0 - initial release
// ============================================================================
module acc_stream_buf
   import acc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int ACC_WIDTH  = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              mode_i,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic                              in_last,
   output logic                              in_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ACC_WIDTH*DATA_WIDTH-1:0]   out_vec,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              out_last,
   output logic [$clog2(ACC_WIDTH+1)-1:0]    out_len
);

   localparam int IDX_W = idx_width(ACC_WIDTH);
   localparam int LEN_W = $clog2(ACC_WIDTH + 1);

   logic                            wr_sel;
   logic                            rd_sel;
   logic [IDX_W-1:0]                wr_idx;
   logic [IDX_W-1:0]                rd_idx;
   out_mode_e                       mode_q;

   logic [1:0]                      full;
   logic [LEN_W-1:0]                bank_len  [2];
   logic [DATA_WIDTH-1:0]           bank_data [2];
   logic [ACC_WIDTH*DATA_WIDTH-1:0] bank_vec  [2];

   logic                            accept;
   logic                            close_now;
   logic                            hs;
   logic                            rd_last;
   logic                            free_now;
   logic [LEN_W-1:0]                close_len;
   logic [LEN_W-1:0]                cur_len;
   logic [DATA_WIDTH-1:0]           cur_data;
   logic [ACC_WIDTH*DATA_WIDTH-1:0] cur_vec;

   // in_ready depends only on registered full flags, so there is no
   // combinational path from out_ready back to the producer.
   assign in_ready  = !full[wr_sel];
   assign accept    = in_valid && in_ready;
   assign close_now = accept && (in_last || (wr_idx == IDX_W'(ACC_WIDTH - 1)));
   assign close_len = LEN_W'(wr_idx) + LEN_W'(1);

   assign out_valid = full[rd_sel];
   assign cur_len   = bank_len[rd_sel];
   assign cur_data  = bank_data[rd_sel];
   assign cur_vec   = bank_vec[rd_sel];

   // Compare against len via idx+1 to avoid an underflow on len-1.
   assign rd_last   = (LEN_W'(rd_idx) + LEN_W'(1)) == cur_len;
   assign hs        = out_valid && out_ready;
   assign free_now  = hs && ((mode_q == MODE_BATCH) || rd_last);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      acc_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_bank (
         .clk        (clk),
         .rst        (rst),
         .wr_en      (accept && (wr_sel == 1'(b))),
         .wr_idx     (wr_idx),
         .wr_data    (in_data),
         .close      (close_now && (wr_sel == 1'(b))),
         .close_len  (close_len),
         .free       (free_now && (rd_sel == 1'(b))),
         .rd_idx     (rd_idx),
         .rd_data    (bank_data[b]),
         .rd_vec     (bank_vec[b]),
         .len        (bank_len[b]),
         .full       (full[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_idx <= '0;
         rd_idx <= '0;
         mode_q <= MODE_BATCH;
      end else begin
         if (accept) begin
            if (close_now) begin
               wr_idx <= '0;
               wr_sel <= !wr_sel;
            end else begin
               wr_idx <= wr_idx + IDX_W'(1);
            end
         end

         if (hs && (mode_q == MODE_STREAM)) begin
            rd_idx <= rd_last ? '0 : rd_idx + IDX_W'(1);
         end

         if (free_now) begin
            rd_sel <= !rd_sel;
         end

         // Mode switches only between vectors so a vector is never split
         // across two delivery modes.
         if ((full == 2'b00) && (rd_idx == '0)) begin
            mode_q <= out_mode_e'(mode_i);
         end
      end
   end

   always_comb begin
      out_data = '0;
      out_last = 1'b0;
      out_len  = '0;
      if (out_valid) begin
         out_len = cur_len;
         if (mode_q == MODE_STREAM) begin
            out_data = cur_data;
            out_last = rd_last;
         end else begin
            out_last = 1'b1;
         end
      end
   end

   // Lanes beyond the stored length read as zero in batch mode.
   for (genvar l = 0; l < ACC_WIDTH; l++) begin : g_lane
      localparam logic [LEN_W-1:0] LANE = LEN_W'(l);
      assign out_vec[l*DATA_WIDTH +: DATA_WIDTH] =
         (out_valid && (mode_q == MODE_BATCH) && (LANE < cur_len)) ?
         cur_vec[l*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

endmodule
`default_nettype wire
